// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu
// Load/store and instruction-fetch unit between the multicycle MIPS core and
// the Avalon-MM master port. It accepts one request at a time, runs exactly
// one Avalon transfer for it, then returns a one-cycle response.
//
// Ports
//   clk_i, reset_i        clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   req_op_i              0 LW 1 LH 2 LHU 3 LB 4 LBU 5 LWL 6 LWR 7 SW 8 SH 9 SB 10 FETCH
//   req_addr_i            byte address
//   req_wdata_i           store data
//   req_rt_i              old rt value, merge source for LWL/LWR
//   resp_valid_o          one-cycle completion pulse
//   resp_data_o           load/fetch result (0 for stores and errors)
//   resp_err_o            misaligned address or illegal opcode
//   bus_timeout_o         sticky: a transfer waited WAIT_TIMEOUT cycles
//   address_o, write_o, read_o, waitrequest_i, writedata_o, byteenable_o,
//   readdata_i            Avalon-MM master
module mips_bus_lsu #(
    parameter int          WAIT_TIMEOUT = 256,
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_rt_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        bus_timeout_o,
    output logic [31:0] address_o,
    output logic        write_o,
    output logic        read_o,
    input  logic        waitrequest_i,
    output logic [31:0] writedata_o,
    output logic [3:0]  byteenable_o,
    input  logic [31:0] readdata_i
);

    localparam logic [3:0] OP_LW    = 4'd0;
    localparam logic [3:0] OP_LH    = 4'd1;
    localparam logic [3:0] OP_LHU   = 4'd2;
    localparam logic [3:0] OP_LB    = 4'd3;
    localparam logic [3:0] OP_LBU   = 4'd4;
    localparam logic [3:0] OP_LWL   = 4'd5;
    localparam logic [3:0] OP_LWR   = 4'd6;
    localparam logic [3:0] OP_SW    = 4'd7;
    localparam logic [3:0] OP_SH    = 4'd8;
    localparam logic [3:0] OP_SB    = 4'd9;
    localparam logic [3:0] OP_FETCH = 4'd10;

    localparam logic [31:0] WT_LIMIT = WAIT_TIMEOUT[31:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] rt_q;
    logic [31:0] waitCnt_q;
    logic        reqReady_q, respValid_q, respErr_q, busTimeout_q;
    logic        read_q, write_q;
    logic [31:0] respData_q, address_q, writedata_q;
    logic [3:0]  byteenable_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        isRead_d, isStore_d, aligned_d;
    logic [1:0]  reqLane;

    assign reqLane = req_addr_i[1:0];

    // Decode the incoming request: lane enables, replicated store data and
    // the alignment/legality verdict that chooses between BUS and RESP.
    always_comb begin
        be_d      = 4'b0000;
        wdata_d   = 32'h0;
        aligned_d = 1'b1;
        isRead_d  = (req_op_i <= OP_LWR) || (req_op_i == OP_FETCH);
        isStore_d = (req_op_i >= OP_SW) && (req_op_i <= OP_SB);
        case (req_op_i)
            OP_LW, OP_FETCH: begin
                be_d      = 4'b1111;
                aligned_d = (reqLane == 2'b00);
            end
            OP_SW: begin
                be_d      = 4'b1111;
                wdata_d   = req_wdata_i;
                aligned_d = (reqLane == 2'b00);
            end
            OP_LH, OP_LHU: begin
                be_d      = 4'b0011 << reqLane;
                aligned_d = ~reqLane[0];
            end
            OP_SH: begin
                be_d      = 4'b0011 << reqLane;
                wdata_d   = {2{req_wdata_i[15:0]}};
                aligned_d = ~reqLane[0];
            end
            OP_LB, OP_LBU: be_d = 4'b0001 << reqLane;
            OP_SB: begin
                be_d    = 4'b0001 << reqLane;
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            OP_LWL, OP_LWR: be_d = 4'b1111;
            default: ;
        endcase
    end

    // Shape the sampled word into the register result. The lane-shifted copy
    // puts the addressed byte/half at bit 0, which also is exactly the LWR
    // contribution from memory.
    function automatic logic [31:0] loadResult(input logic [3:0] op,
                                               input logic [1:0] b,
                                               input logic [31:0] m,
                                               input logic [31:0] rt);
        logic [31:0] sh;
        sh = m >> {b, 3'b000};
        loadResult = m;
        case (op)
            OP_LB:  loadResult = {{24{sh[7]}}, sh[7:0]};
            OP_LBU: loadResult = {24'h0, sh[7:0]};
            OP_LH:  loadResult = {{16{sh[15]}}, sh[15:0]};
            OP_LHU: loadResult = {16'h0, sh[15:0]};
            OP_LWL: begin
                case (b)
                    2'd0:    loadResult = (m << 24) | (rt & 32'h00FF_FFFF);
                    2'd1:    loadResult = (m << 16) | (rt & 32'h0000_FFFF);
                    2'd2:    loadResult = (m << 8)  | (rt & 32'h0000_00FF);
                    default: loadResult = m;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0:    loadResult = m;
                    2'd1:    loadResult = sh | (rt & 32'hFF00_0000);
                    2'd2:    loadResult = sh | (rt & 32'hFFFF_0000);
                    default: loadResult = sh | (rt & 32'hFFFF_FF00);
                endcase
            end
            default: loadResult = m;
        endcase
    endfunction

    // Main controller. All outputs are registers updated here so the core and
    // the bus only ever see glitch-free, edge-aligned values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LW;
            lane_q       <= 2'b00;
            rt_q         <= 32'h0;
            waitCnt_q    <= 32'h0;
            reqReady_q   <= 1'b1;
            respValid_q  <= 1'b0;
            respErr_q    <= 1'b0;
            respData_q   <= 32'h0;
            busTimeout_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= RESET_ADDR;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q       <= req_op_i;
                        lane_q     <= reqLane;
                        rt_q       <= req_rt_i;
                        reqReady_q <= 1'b0;
                        if ((isRead_d || isStore_d) && aligned_d) begin
                            state_q      <= S_BUS;
                            address_q    <= {req_addr_i[31:2], 2'b00};
                            read_q       <= isRead_d;
                            write_q      <= isStore_d;
                            byteenable_q <= be_d;
                            writedata_q  <= wdata_d;
                            waitCnt_q    <= 32'h0;
                        end else begin
                            // Bad requests answer straight away without
                            // ever driving the bus.
                            state_q     <= S_RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            respData_q  <= 32'h0;
                        end
                    end
                end
                S_BUS: begin
                    if (waitrequest_i) begin
                        // The transfer is never abandoned; the monitor only
                        // raises the sticky flag and then saturates.
                        if ((WT_LIMIT != 32'h0) && (waitCnt_q != WT_LIMIT)) begin
                            waitCnt_q <= waitCnt_q + 32'h1;
                            if (waitCnt_q + 32'h1 == WT_LIMIT) begin
                                busTimeout_q <= 1'b1;
                            end
                        end
                    end else begin
                        state_q      <= S_RESP;
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        byteenable_q <= 4'b0000;
                        writedata_q  <= 32'h0;
                        respValid_q  <= 1'b1;
                        respErr_q    <= 1'b0;
                        respData_q   <= read_q ? loadResult(op_q, lane_q, readdata_i, rt_q)
                                               : 32'h0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    respValid_q <= 1'b0;
                    respErr_q   <= 1'b0;
                    reqReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o   = reqReady_q;
    assign resp_valid_o  = respValid_q;
    assign resp_data_o   = respData_q;
    assign resp_err_o    = respErr_q;
    assign bus_timeout_o = busTimeout_q;
    assign address_o     = address_q;
    assign write_o       = write_q;
    assign read_o        = read_q;
    assign writedata_o   = writedata_q;
    assign byteenable_o  = byteenable_q;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed testbench for mips_bus_lsu. A small Avalon slave model inside
// runTx answers each transfer after a chosen number of waitrequest cycles,
// and each test task compares what it observed with hand-computed values.
module tb_mips_bus_lsu;

    localparam logic [31:0] RST_ADDR = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [3:0]  reqOp;
    logic [31:0] reqAddr, reqWdata, reqRt;
    logic        respValid;
    logic [31:0] respData;
    logic        respErr;
    logic        busTimeout;
    logic [31:0] address;
    logic        write, read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    // Observations gathered by runTx for the test tasks to judge.
    logic        obsReadyAtReq;
    int          obsRdCycles, obsWrCycles, obsBoth, obsRespCount;
    int          obsRespLat, obsReadyLat, obsTimeoutK;
    logic [31:0] obsAddr, obsWd, obsRespData;
    logic [3:0]  obsBe;
    logic        obsStable, obsRespErr;

    mips_bus_lsu #(.WAIT_TIMEOUT(4), .RESET_ADDR(RST_ADDR)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_op_i(reqOp), .req_addr_i(reqAddr),
        .req_wdata_i(reqWdata), .req_rt_i(reqRt),
        .resp_valid_o(respValid), .resp_data_o(respData),
        .resp_err_o(respErr), .bus_timeout_o(busTimeout),
        .address_o(address), .write_o(write), .read_o(read),
        .waitrequest_i(waitrequest), .writedata_o(writedata),
        .byteenable_o(byteenable), .readdata_i(readdata)
    );

    always #5 clk = ~clk;

    // Issue one request and play the slave: the first `waits` bus cycles are
    // stalled with junk on readdata, then the real word is presented.
    // Cycle k is observed at the falling edge after the k-th rising edge
    // counted from the accepting edge.
    task automatic runTx(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt,
                         input int waits, input logic [31:0] rdata);
        int k;
        int busSeen;
        obsRdCycles = 0; obsWrCycles = 0; obsBoth = 0; obsRespCount = 0;
        obsRespLat = 0; obsReadyLat = 0; obsTimeoutK = 0;
        obsAddr = 32'h0; obsWd = 32'h0; obsBe = 4'h0; obsStable = 1'b1;
        obsRespData = 32'h0; obsRespErr = 1'b0;
        busSeen = 0;
        @(negedge clk);
        reqOp = op; reqAddr = addr; reqWdata = wdata; reqRt = rt;
        reqValid = 1'b1;
        waitrequest = 1'b0;
        readdata = 32'h5A5A_5A5A;
        obsReadyAtReq = reqReady;
        @(posedge clk);
        #1 reqValid = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busTimeout && obsTimeoutK == 0) obsTimeoutK = k;
            if (read || write) begin
                busSeen++;
                if (read) obsRdCycles++;
                if (write) obsWrCycles++;
                if (read && write) obsBoth++;
                if (busSeen == 1) begin
                    obsAddr = address; obsBe = byteenable; obsWd = writedata;
                end else if (address !== obsAddr || byteenable !== obsBe ||
                             writedata !== obsWd) begin
                    obsStable = 1'b0;
                end
                waitrequest = (busSeen <= waits);
                readdata = (busSeen <= waits) ? ~rdata : rdata;
            end else begin
                waitrequest = 1'b0;
                readdata = 32'h5A5A_5A5A;
            end
            if (respValid) begin
                obsRespCount++;
                if (obsRespLat == 0) begin
                    obsRespLat = k; obsRespData = respData; obsRespErr = respErr;
                end
            end
            if (obsRespLat != 0 && k > obsRespLat && reqReady) begin
                obsReadyLat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1 || read !== 1'b0 || write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready=%b read=%b write=%b, want 1 0 0", reqReady, read, write);
        end
        checks++;
        if (address !== RST_ADDR || byteenable !== 4'h0 || writedata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: addr=%h be=%h wd=%h, want %h 0 0", address, byteenable, writedata, RST_ADDR);
        end
        checks++;
        if (respValid !== 1'b0 || respData !== 32'h0 || respErr !== 1'b0 || busTimeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp: valid=%b data=%h err=%b to=%b, want all 0", respValid, respData, respErr, busTimeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw_basic();
        runTx(4'd0, 32'h0000_0100, 32'h0, 32'h0, 0, 32'hDEAD_BEEF);
        checks++;
        if (obsReadyAtReq !== 1'b1 || obsRdCycles != 1 || obsWrCycles != 0) begin
            errors++;
            $display("[TB] FAIL lw_strobes: ready=%b rd=%0d wr=%0d, want 1 1 0", obsReadyAtReq, obsRdCycles, obsWrCycles);
        end
        checks++;
        if (obsAddr !== 32'h100 || obsBe !== 4'hF || obsWd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL lw_bus: addr=%h be=%h wd=%h, want 100 f 0", obsAddr, obsBe, obsWd);
        end
        checks++;
        if (obsRespLat != 2 || obsRespCount != 1 || obsReadyLat != 3) begin
            errors++;
            $display("[TB] FAIL lw_timing: resp@%0d x%0d ready@%0d, want 2 1 3", obsRespLat, obsRespCount, obsReadyLat);
        end
        checks++;
        if (obsRespData !== 32'hDEAD_BEEF || obsRespErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_data: %h err=%b, want deadbeef 0", obsRespData, obsRespErr);
        end
    endtask

    task automatic test_sub_word_loads();
        // op, addr, readdata, expected be, expected result
        logic [3:0]  ops  [6] = '{4'd3, 4'd4, 4'd1, 4'd2, 4'd1, 4'd4};
        logic [31:0] adrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
        logic [31:0] mems [6] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233,
                                  32'h8011_2233, 32'h1234_7FFF, 32'h1234_56F0};
        logic [3:0]  bes  [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0010};
        logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011,
                                  32'h0000_8011, 32'h0000_7FFF, 32'h0000_0056};
        for (int i = 0; i < 6; i++) begin
            runTx(ops[i], adrs[i], 32'h0, 32'h0, 1, mems[i]);
            checks++;
            if (obsAddr !== 32'h100 || obsBe !== bes[i] || obsRespData !== exps[i] || obsRespErr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL subword_%0d: addr=%h be=%b data=%h, want 100 %b %h", i, obsAddr, obsBe, obsRespData, bes[i], exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        runTx(4'd8, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 32'h0);
        checks++;
        if (obsWrCycles != 4 || obsRdCycles != 0 || obsBoth != 0 || obsStable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sh_strobes: wr=%0d rd=%0d stable=%b, want 4 0 1", obsWrCycles, obsRdCycles, obsStable);
        end
        checks++;
        if (obsAddr !== 32'h200 || obsBe !== 4'b1100 || obsWd !== 32'hABCD_ABCD) begin
            errors++;
            $display("[TB] FAIL sh_bus: addr=%h be=%b wd=%h, want 200 1100 abcdabcd", obsAddr, obsBe, obsWd);
        end
        checks++;
        if (obsRespLat != 5 || obsReadyLat != 6 || obsRespData !== 32'h0 || obsRespErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sh_resp: resp@%0d ready@%0d data=%h err=%b, want 5 6 0 0", obsRespLat, obsReadyLat, obsRespData, obsRespErr);
        end
        runTx(4'd9, 32'h0000_0201, 32'h7777_775A, 32'h0, 0, 32'h0);
        checks++;
        if (obsWrCycles != 1 || obsBe !== 4'b0010 || obsWd !== 32'h5A5A_5A5A) begin
            errors++;
            $display("[TB] FAIL sb_bus: wr=%0d be=%b wd=%h, want 1 0010 5a5a5a5a", obsWrCycles, obsBe, obsWd);
        end
        runTx(4'd7, 32'h0000_0300, 32'h0BAD_F00D, 32'h0, 0, 32'h0);
        checks++;
        if (obsWrCycles != 1 || obsAddr !== 32'h300 || obsBe !== 4'hF || obsWd !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL sw_bus: wr=%0d addr=%h be=%h wd=%h, want 1 300 f 0badf00d", obsWrCycles, obsAddr, obsBe, obsWd);
        end
    endtask

    task automatic test_lwl_lwr();
        logic [3:0]  ops  [6] = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd5, 4'd6};
        logic [31:0] adrs [6] = '{32'h301, 32'h301, 32'h303, 32'h300, 32'h300, 32'h303};
        logic [31:0] exps [6] = '{32'h3344_CCDD, 32'hAA11_2233, 32'h1122_3344,
                                  32'h1122_3344, 32'h44BB_CCDD, 32'hAABB_CC11};
        for (int i = 0; i < 6; i++) begin
            runTx(ops[i], adrs[i], 32'h0, 32'hAABB_CCDD, 0, 32'h1122_3344);
            checks++;
            if (obsBe !== 4'hF || obsRespData !== exps[i] || obsRespErr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL merge_%0d: be=%h data=%h, want f %h", i, obsBe, obsRespData, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0]  ops  [4] = '{4'd0, 4'd13, 4'd8, 4'd10};
        logic [31:0] adrs [4] = '{32'h102, 32'h100, 32'h201, 32'h106};
        for (int i = 0; i < 4; i++) begin
            runTx(ops[i], adrs[i], 32'hFFFF_FFFF, 32'h0, 0, 32'h1234_5678);
            checks++;
            if (obsRdCycles != 0 || obsWrCycles != 0 || obsRespLat != 1 || obsReadyLat != 2 ||
                obsRespErr !== 1'b1 || obsRespData !== 32'h0 || obsRespCount != 1) begin
                errors++;
                $display("[TB] FAIL error_%0d: rd=%0d wr=%0d resp@%0d ready@%0d err=%b data=%h, want 0 0 1 2 1 0",
                         i, obsRdCycles, obsWrCycles, obsRespLat, obsReadyLat, obsRespErr, obsRespData);
            end
        end
        runTx(4'd10, 32'h0000_0104, 32'h0, 32'h0, 0, 32'h2402_0007);
        checks++;
        if (obsRdCycles != 1 || obsRespErr !== 1'b0 || obsRespData !== 32'h2402_0007 || obsAddr !== 32'h104) begin
            errors++;
            $display("[TB] FAIL fetch: rd=%0d err=%b data=%h addr=%h, want 1 0 24020007 104", obsRdCycles, obsRespErr, obsRespData, obsAddr);
        end
    endtask

    task automatic test_timeout();
        checks++;
        if (busTimeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pre: %b, want 0", busTimeout);
        end
        runTx(4'd0, 32'h0000_0400, 32'h0, 32'h0, 6, 32'hCAFE_F00D);
        checks++;
        if (obsTimeoutK != 5) begin
            errors++;
            $display("[TB] FAIL timeout_rise: cycle %0d, want 5", obsTimeoutK);
        end
        checks++;
        if (obsRdCycles != 7 || obsRespLat != 8 || obsRespData !== 32'hCAFE_F00D || obsRespErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_xfer: rd=%0d resp@%0d data=%h err=%b, want 7 8 cafef00d 0", obsRdCycles, obsRespLat, obsRespData, obsRespErr);
        end
        checks++;
        if (busTimeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: %b, want 1", busTimeout);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int sawResp;
        sawResp = 0;
        @(negedge clk);
        reqOp = 4'd0; reqAddr = 32'h500; reqValid = 1'b1;
        waitrequest = 1'b1; readdata = 32'h1111_1111;
        @(posedge clk);
        #1 reqValid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (read !== 1'b1 || busTimeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pre: read=%b to=%b, want 1 1", read, busTimeout);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (read !== 1'b0 || busTimeout !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b1 || address !== RST_ADDR) begin
            errors++;
            $display("[TB] FAIL midreset_post: read=%b to=%b rv=%b ready=%b addr=%h, want 0 0 0 1 %h",
                     read, busTimeout, respValid, reqReady, address, RST_ADDR);
        end
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (respValid) sawResp++;
        end
        checks++;
        if (sawResp != 0) begin
            errors++;
            $display("[TB] FAIL midreset_noresp: %0d pulses, want 0", sawResp);
        end
        runTx(4'd4, 32'h0000_0602, 32'h0, 32'h0, 0, 32'h00C3_0000);
        checks++;
        if (obsRespData !== 32'h0000_00C3 || obsRespLat != 2) begin
            errors++;
            $display("[TB] FAIL midreset_recover: data=%h resp@%0d, want c3 2", obsRespData, obsRespLat);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reqValid = 1'b0; reqOp = 4'd0; reqAddr = 32'h0; reqWdata = 32'h0; reqRt = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        test_reset();
        test_lw_basic();
        test_sub_word_loads();
        test_stores();
        test_lwl_lwr();
        test_errors();
        test_timeout();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Load/store and fetch unit sitting between the multicycle MIPS core and the Avalon memory-mapped master port of `mips_cpu_bus`. It accepts one request at a time from the core's FETCH/EXEC states and runs exactly one Avalon transfer per request. Around that transfer it handles:
- waitrequest stalls;
- byte-lane steering and byteenable generation;
- sign/zero extension and LWL/LWR merging;
- alignment checking and a wait-timeout monitor.

## Interface
Parameters:
- `WAIT_TIMEOUT`, default 256: waitrequest cycles on one transfer before `bus_timeout` is set. 0 disables the monitor.
- `RESET_ADDR`, default 32'h0000_0000: value driven on `address` while idle after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept. High only in IDLE.
- `req_op`  in  4  operation code:
  - 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWL, 6 LWR;
  - 7 SW, 8 SH, 9 SB;
  - 10 FETCH;
  - 11–15 illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data. Only the low byte/half is used for SB/SH.
- `req_rt`  in  32  old rt value, used as the merge source for LWL/LWR.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  load/fetch result. 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`. Set for a misaligned address or an illegal op.
- `bus_timeout`  out  1  sticky flag. Cleared only by reset.
- Avalon master:
  - `address`  out 32
  - `write`  out 1
  - `read`  out 1
  - `waitrequest`  in 1
  - `writedata`  out 32
  - `byteenable`  out 4
  - `readdata`  in 32

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, addr, wdata and rt.
  - Legal and aligned request → BUS. Otherwise → RESP with the error flagged.
- Alignment rules, using b = `req_addr[1:0]`:
  - LW, SW, FETCH require b=0.
  - LH, LHU, SH require b[0]=0.
  - LB, LBU, SB, LWL, LWR: any b.
- BUS:
  - Reads (ops 0–6, 10) assert `read`; stores assert `write`. Never both.
  - `address` = {addr[31:2],2'b00}.
  - `address`, `byteenable` and `writedata` are stable for the whole BUS state.
  - Stay in BUS while `waitrequest`=1.
  - On the first cycle with `waitrequest`=0 the transfer completes and `readdata` is sampled that same cycle. Next state is RESP.
- Byteenable and write data (little-endian lanes):
  - LW, FETCH, LWL, LWR, SW: 4'b1111.
  - LH, LHU: 4'b0011<<b. LB, LBU: 4'b0001<<b.
  - SH: 4'b0011<<b, `writedata`={2{wdata[15:0]}}.
  - SB: 4'b0001<<b, `writedata`={4{wdata[7:0]}}.
  - Reads drive `writedata`=0.
- Load results, with m = sampled `readdata`:
  - LB/LBU: byte m[8b+7:8b], sign-/zero-extended.
  - LH/LHU: half m[8b+15:8b], sign-/zero-extended.
  - LW/FETCH: m.
  - LWL: (m << 8(3-b)) | (rt & (32'hFFFFFFFF >> 8(b+1))). b=3 gives m.
  - LWR: (m >> 8b) | (rt & ~(32'hFFFFFFFF >> 8b)). b=0 gives m.
- RESP:
  - `resp_valid`=1 for exactly one cycle, with `resp_data` and `resp_err`. Then → IDLE.
  - Error responses never touch the bus.
- Timeout monitor:
  - Counter is cleared on entry to BUS and increments each BUS cycle with `waitrequest`=1.
  - When the count reaches `WAIT_TIMEOUT`, `bus_timeout` is set.
  - The transfer is not aborted; the unit keeps waiting, as required by the Avalon protocol.
  - The counter saturates at the limit.

## Timing
- Every output is registered.
- Values after a reset edge:
  - state IDLE, `req_ready`=1;
  - `read`=`write`=0, `byteenable`=0, `writedata`=0, `address`=`RESET_ADDR`;
  - `resp_valid`=0, `resp_data`=0, `resp_err`=0, `bus_timeout`=0.
- Accept at edge N → `read`/`write` high from cycle N+1.
- With zero wait states: `resp_valid` at N+2, `req_ready` again at N+3. Each waitrequest cycle adds one cycle.
- Error path: accept at N → `resp_valid`+`resp_err` at N+1 → IDLE at N+2.
- `req_valid` while not ready is ignored. The core must hold its request until accepted.
- Reset during BUS or RESP:
  - `read`/`write` drop at the reset edge and the response is discarded (no `resp_valid`).
  - `bus_timeout` clears.
- `readdata` is ignored on every cycle except the completing read cycle.

## Test plan
- LW 0x100 with 0 wait states, `readdata`=0xDEADBEEF → `read` for 1 cycle, `byteenable`=4'hF, `address`=0x100; `resp_valid` 2 cycles after accept with `resp_data`=0xDEADBEEF.
- LB 0x103 with `readdata`=0x80112233, then LBU 0x103 → `address`=0x100, `byteenable`=4'b1000; results 0xFFFFFF80 and 0x00000080.
- SH 0x202, `req_wdata`=0x1234ABCD, `waitrequest` high 3 cycles → `write` held 4 cycles, `byteenable`=4'b1100, `writedata`=0xABCDABCD, stable throughout; `resp_valid` 1 cycle later.
- LWL 0x301 and LWR 0x301, `rt`=0xAABBCCDD, `readdata`=0x11223344 → 0x3344CCDD and 0xAA112233.
- LW 0x102 → no bus activity, `resp_err`=1 one cycle after accept; op 13 behaves the same.
- `WAIT_TIMEOUT`=4, `waitrequest` high 6 cycles → `bus_timeout` rises after the 4th wait cycle and the read completes normally; then assert reset mid-transfer → `read` low next edge, no `resp_valid`, `bus_timeout`=0.
